// File: rtl/allophone_sequencer.sv
// Allophone queue and issue scheduler feeding the Speech256 load handshake.
// A circular buffer of 6-bit codes is issued one per ldq high/low cycle.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a queued code and ldq high; may pulse done
// WAIT_ACK | code strobed, waiting for the core to drop ldq
module allophone_sequencer #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [5:0]    wr_data,
   input  logic          wr_stb,
   input  logic          flush,
   output logic          full,
   output logic [AW:0]   count,
   output logic          overflow,
   input  logic          ldq,
   output logic [5:0]    data_out,
   output logic          data_stb,
   output logic          busy,
   output logic          done
);

   typedef enum logic {IDLE, WAIT_ACK} state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   state_t        state, state_n;
   logic [5:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic [AW:0]   count_n;
   logic          overflow_n, armed, armed_n;
   logic [5:0]    data_out_n;
   logic          data_stb_n, done_n, full_n, busy_n;
   logic          push, pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         armed    <= 1'b0;
         data_out <= '0;
         data_stb <= 1'b0;
         done     <= 1'b0;
         full     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         wr_ptr   <= wr_ptr_n;
         rd_ptr   <= rd_ptr_n;
         count    <= count_n;
         overflow <= overflow_n;
         armed    <= armed_n;
         data_out <= data_out_n;
         data_stb <= data_stb_n;
         done     <= done_n;
         full     <= full_n;
         busy     <= busy_n;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_comb begin
      state_n    = state;
      wr_ptr_n   = wr_ptr;
      rd_ptr_n   = rd_ptr;
      count_n    = count;
      overflow_n = overflow;
      armed_n    = armed;
      data_out_n = data_out;
      data_stb_n = 1'b0;
      done_n     = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;

      // flush discards the queue but leaves the handshake state untouched
      if (flush) begin
         wr_ptr_n   = '0;
         rd_ptr_n   = '0;
         count_n    = '0;
         overflow_n = 1'b0;
         armed_n    = 1'b0;
      end else begin
         push = wr_stb && (count != FULL_CNT);
         if (wr_stb && (count == FULL_CNT)) overflow_n = 1'b1;
      end

      case (state)
         IDLE: begin
            if (!flush && ldq && (count != '0)) begin
               pop        = 1'b1;
               data_stb_n = 1'b1;
               data_out_n = mem[rd_ptr];
               armed_n    = 1'b1;
               state_n    = WAIT_ACK;
            end else if (!flush && ldq && armed && (count == '0)) begin
               done_n  = 1'b1;
               armed_n = 1'b0;
            end
         end
         WAIT_ACK: begin
            if (!ldq) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      if (!flush) begin
         if (push) wr_ptr_n = wr_ptr + AW'(1);
         if (pop)  rd_ptr_n = rd_ptr + AW'(1);
         if (push && !pop)      count_n = count + (AW+1)'(1);
         else if (pop && !push) count_n = count - (AW+1)'(1);
      end

      full_n = (count_n == FULL_CNT);
      busy_n = (count_n != '0) || (state_n == WAIT_ACK);
   end

endmodule

// File: tb/tb_allophone_sequencer.sv
// Directed bench for allophone_sequencer: a cycle table for the basic
// handshake plus scripted sequences with a simple core ack model.
module tb_allophone_sequencer;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk;
   logic          rst;
   logic [5:0]    wr_data;
   logic          wr_stb;
   logic          flush;
   logic          full;
   logic [AW:0]   count;
   logic          overflow;
   logic          ldq;
   logic [5:0]    data_out;
   logic          data_stb;
   logic          busy;
   logic          done;

   allophone_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .wr_data(wr_data), .wr_stb(wr_stb), .flush(flush),
      .full(full), .count(count), .overflow(overflow), .ldq(ldq),
      .data_out(data_out), .data_stb(data_stb), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       wr;
      logic [5:0] wd;
      logic       fl;
      logic       lq;
      logic [3:0] cnt;
      logic       full;
      logic       ovf;
      logic       stb;
      logic [5:0] dout;
      logic       busy;
      logic       done;
   } vec_t;

   int n_chk;
   int n_fail;
   int hold;
   int done_cnt;
   int dbl;
   int stb_cnt;
   logic prev_stb;
   logic [5:0] wq[$];
   logic [5:0] cap_q[$];
   logic [5:0] exp_q[$];
   vec_t vecs[17];

   function automatic vec_t mk(input int r, input int w, input int wd, input int fl,
                               input int lq, input int cnt, input int fu, input int ov,
                               input int st, input int dout, input int bu, input int dn);
      vec_t v;
      v.rst = 1'(r);   v.wr = 1'(w);     v.wd = 6'(wd);    v.fl = 1'(fl);
      v.lq = 1'(lq);   v.cnt = 4'(cnt);  v.full = 1'(fu);  v.ovf = 1'(ov);
      v.stb = 1'(st);  v.dout = 6'(dout); v.busy = 1'(bu); v.done = 1'(dn);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; wr_stb = 1'b0; flush = 1'b0;
      step();
      rst = 1'b0;
   endtask

   // Core model: after each strobe ldq stays low for ack_len cycles, then returns high.
   task automatic run_core(input int cycles, input int ack_len);
      for (int i = 0; i < cycles; i++) begin
         if (wq.size() > 0 && count < 4'(DEPTH)) begin
            wr_stb  = 1'b1;
            wr_data = wq.pop_front();
         end else begin
            wr_stb = 1'b0;
         end
         ldq = (hold == 0);
         step();
         wr_stb = 1'b0;
         if (data_stb) begin
            cap_q.push_back(data_out);
            if (prev_stb) dbl++;
            hold = ack_len;
         end else if (hold > 0) begin
            hold--;
         end
         prev_stb = data_stb;
         if (done) done_cnt++;
      end
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      rst = 1'b1; wr_stb = 1'b0; wr_data = '0; flush = 1'b0; ldq = 1'b1;
      step(); step();

      vecs[0]  = mk(1,0,'h00,0,1, 0,0,0,0,'h00,0,0);
      vecs[1]  = mk(0,1,'h05,0,1, 1,0,0,0,'h00,1,0);
      vecs[2]  = mk(0,1,'h2A,0,1, 1,0,0,1,'h05,1,0);
      vecs[3]  = mk(0,0,'h00,0,1, 1,0,0,0,'h05,1,0);
      vecs[4]  = mk(0,0,'h00,0,0, 1,0,0,0,'h05,1,0);
      vecs[5]  = mk(0,0,'h00,0,1, 0,0,0,1,'h2A,1,0);
      vecs[6]  = mk(0,0,'h00,0,0, 0,0,0,0,'h2A,0,0);
      vecs[7]  = mk(0,0,'h00,0,1, 0,0,0,0,'h2A,0,1);
      vecs[8]  = mk(0,0,'h00,0,1, 0,0,0,0,'h2A,0,0);
      vecs[9]  = mk(0,1,'h11,1,1, 0,0,0,0,'h2A,0,0);
      vecs[10] = mk(0,1,'h3F,0,0, 1,0,0,0,'h2A,1,0);
      vecs[11] = mk(0,1,'h01,0,0, 2,0,0,0,'h2A,1,0);
      vecs[12] = mk(0,0,'h00,0,1, 1,0,0,1,'h3F,1,0);
      vecs[13] = mk(0,1,'h02,0,1, 2,0,0,0,'h3F,1,0);
      vecs[14] = mk(0,0,'h00,0,0, 2,0,0,0,'h3F,1,0);
      vecs[15] = mk(0,0,'h00,1,1, 0,0,0,0,'h3F,0,0);
      vecs[16] = mk(0,0,'h00,0,1, 0,0,0,0,'h3F,0,0);

      for (int i = 0; i < 17; i++) begin
         rst = vecs[i].rst; wr_stb = vecs[i].wr; wr_data = vecs[i].wd;
         flush = vecs[i].fl; ldq = vecs[i].lq;
         step();
         chk($sformatf("vec%0d count", i),    32'(count),    32'(vecs[i].cnt));
         chk($sformatf("vec%0d full", i),     32'(full),     32'(vecs[i].full));
         chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].ovf));
         chk($sformatf("vec%0d data_stb", i), 32'(data_stb), 32'(vecs[i].stb));
         chk($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].dout));
         chk($sformatf("vec%0d busy", i),     32'(busy),     32'(vecs[i].busy));
         chk($sformatf("vec%0d done", i),     32'(done),     32'(vecs[i].done));
      end
      rst = 1'b0; wr_stb = 1'b0; flush = 1'b0;

      // Three codes through a core that acks for 10 cycles
      do_reset();
      hold = 0; done_cnt = 0; dbl = 0; prev_stb = 1'b0;
      cap_q.delete(); wq.delete();
      wq.push_back(6'h05); wq.push_back(6'h2A); wq.push_back(6'h3F);
      run_core(60, 10);
      chk("seq3 issued", 32'(cap_q.size()), 32'd3);
      if (cap_q.size() == 3) begin
         chk("seq3 code0", 32'(cap_q[0]), 32'h05);
         chk("seq3 code1", 32'(cap_q[1]), 32'h2A);
         chk("seq3 code2", 32'(cap_q[2]), 32'h3F);
      end
      chk("seq3 double strobe", 32'(dbl), 32'd0);
      chk("seq3 done pulses", 32'(done_cnt), 32'd1);
      chk("seq3 busy end", 32'(busy), 32'd0);

      // Fill with the core stalled, then overflow
      do_reset();
      ldq = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wr_stb = 1'b1; wr_data = 6'(8'h10 + i);
         step();
      end
      wr_stb = 1'b0;
      chk("fill full", 32'(full), 32'd1);
      chk("fill count", 32'(count), 32'd8);
      chk("fill overflow", 32'(overflow), 32'd1);
      hold = 0; done_cnt = 0; dbl = 0; prev_stb = 1'b0; cap_q.delete();
      run_core(150, 10);
      chk("fill issued", 32'(cap_q.size()), 32'd8);
      for (int i = 0; i < cap_q.size() && i < 8; i++)
         chk($sformatf("fill code%0d", i), 32'(cap_q[i]), 32'(8'h10 + i));
      chk("fill overflow sticky", 32'(overflow), 32'd1);
      chk("fill drained", 32'(count), 32'd0);

      // ldq held high after the first strobe
      do_reset();
      ldq = 1'b1; stb_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         wr_stb = 1'b1; wr_data = 6'(i + 1);
         step();
         if (data_stb) stb_cnt++;
      end
      wr_stb = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (data_stb) stb_cnt++;
      end
      chk("stuck strobes", 32'(stb_cnt), 32'd1);
      chk("stuck busy", 32'(busy), 32'd1);
      chk("stuck count", 32'(count), 32'd2);

      // Simultaneous push/pop at count 4, then wrap well past 2*DEPTH
      do_reset();
      ldq = 1'b0; exp_q.delete(); cap_q.delete(); wq.delete();
      for (int i = 0; i < 4; i++) begin
         wr_stb = 1'b1; wr_data = 6'(8'h20 + i); exp_q.push_back(6'(8'h20 + i));
         step();
      end
      ldq = 1'b1; wr_stb = 1'b1; wr_data = 6'h24; exp_q.push_back(6'h24);
      step();
      wr_stb = 1'b0;
      chk("pushpop count", 32'(count), 32'd4);
      chk("pushpop strobe", 32'(data_stb), 32'd1);
      chk("pushpop data", 32'(data_out), 32'h20);
      if (data_stb) cap_q.push_back(data_out);
      for (int i = 0; i < 20; i++) begin
         wq.push_back(6'(8'h25 + i));
         exp_q.push_back(6'(8'h25 + i));
      end
      hold = 1; dbl = 0; prev_stb = 1'b1; done_cnt = 0;
      run_core(200, 1);
      chk("wrap issued", 32'(cap_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
         chk($sformatf("wrap code%0d", i), 32'(cap_q[i]), 32'(exp_q[i]));
      chk("wrap overflow", 32'(overflow), 32'd0);
      chk("wrap double strobe", 32'(dbl), 32'd0);

      // flush in WAIT_ACK with a same-cycle write
      do_reset();
      ldq = 1'b0;
      for (int i = 0; i < 6; i++) begin
         wr_stb = 1'b1; wr_data = 6'(8'h30 + i);
         step();
      end
      wr_stb = 1'b0; ldq = 1'b1;
      step();
      chk("flush pre strobe", 32'(data_stb), 32'd1);
      chk("flush pre count", 32'(count), 32'd5);
      flush = 1'b1; wr_stb = 1'b1; wr_data = 6'h3A;
      step();
      flush = 1'b0; wr_stb = 1'b0;
      chk("flush count", 32'(count), 32'd0);
      chk("flush overflow", 32'(overflow), 32'd0);
      chk("flush busy waitack", 32'(busy), 32'd1);
      stb_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (data_stb) stb_cnt++;
         if (done) done_cnt++;
      end
      ldq = 1'b0;
      step();
      ldq = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         if (data_stb) stb_cnt++;
         if (done) done_cnt++;
      end
      chk("flush no strobe", 32'(stb_cnt), 32'd0);
      chk("flush no done", 32'(done_cnt), 32'd0);
      chk("flush busy idle", 32'(busy), 32'd0);
      wr_stb = 1'b1; wr_data = 6'h15;
      step();
      wr_stb = 1'b0;
      chk("flush rewrite no stb", 32'(data_stb), 32'd0);
      step();
      chk("flush rewrite stb", 32'(data_stb), 32'd1);
      chk("flush rewrite data", 32'(data_out), 32'h15);

      // rst in the strobe cycle
      do_reset();
      ldq = 1'b1; wr_stb = 1'b1; wr_data = 6'h0C;
      step();
      wr_stb = 1'b0;
      step();
      chk("rst pre strobe", 32'(data_stb), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst count", 32'(count), 32'd0);
      chk("rst full", 32'(full), 32'd0);
      chk("rst overflow", 32'(overflow), 32'd0);
      chk("rst data_stb", 32'(data_stb), 32'd0);
      chk("rst data_out", 32'(data_out), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      wr_stb = 1'b1; wr_data = 6'h33;
      step();
      wr_stb = 1'b0;
      chk("rst rewrite no stb", 32'(data_stb), 32'd0);
      chk("rst rewrite count", 32'(count), 32'd1);
      step();
      chk("rst rewrite stb", 32'(data_stb), 32'd1);
      chk("rst rewrite data", 32'(data_out), 32'h33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
